// File: rtl/mesi_isc_mon_pkg.sv
// Shared types, MESI/controller encodings and helpers for the coherence monitor.
package mesi_isc_mon_pkg;

  localparam int unsigned MESI_W = 4;

  // Encodings mirror the mesi_isc test-bench defines
  localparam logic [3:0] MESI_M = 4'b1001;
  localparam logic [3:0] MESI_E = 4'b0101;
  localparam logic [3:0] MESI_S = 4'b0011;
  localparam logic [3:0] MESI_I = 4'b0000;

  localparam logic [2:0] M_STATE_IDLE     = 3'd0;
  localparam logic [2:0] M_STATE_WR_CACHE = 3'd1;
  localparam logic [3:0] C_STATE_IDLE     = 4'd0;

  localparam logic [3:0] INS_NOP = 4'd0;
  localparam logic [3:0] INS_WR  = 4'd1;

  typedef enum logic [1:0] {
    VIOL_NONE        = 2'd0,
    VIOL_MULTI_OWNER = 2'd1,
    VIOL_ILLEGAL_ENC = 2'd2,
    VIOL_WR_TIMEOUT  = 2'd3
  } viol_code_t;

  typedef enum logic {
    TRK_IDLE  = 1'b0,
    TRK_ARMED = 1'b1
  } trk_state_t;

  typedef struct packed {
    viol_code_t  code;
    logic [3:0]  line;
    logic [1:0]  cpu;
  } viol_rec_t;

  typedef struct packed {
    logic       hit;
    viol_rec_t  rec;
  } line_res_t;

  function automatic logic is_owner(input logic [3:0] st);
    return (st == MESI_M) || (st == MESI_E);
  endfunction

  function automatic logic is_legal(input logic [3:0] st);
    return (st == MESI_M) || (st == MESI_E) || (st == MESI_S) || (st == MESI_I);
  endfunction

endpackage

// File: rtl/mesi_isc_mon_wr_tracker.sv
// CPU0 write-hit latency tracker: arms on a write to an owned line, times the
// wait for WR_CACHE and flags a timeout.
module mesi_isc_mon_wr_tracker
  import mesi_isc_mon_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 10,
  parameter int unsigned WR_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [MESI_W*NUM_LINES-1:0]   i_state_cpu0,
  input  logic [3:0]                    i_c_state,
  input  logic [2:0]                    i_m_state,
  input  logic [3:0]                    i_tb_ins,
  input  logic [3:0]                    i_tb_ins_addr,
  output logic                          o_done_c,
  output logic                          o_timeout_c,
  output logic [CNT_W-1:0]              o_lat_c,
  output logic [3:0]                    o_addr_c
);

  trk_state_t        r_state;
  trk_state_t        w_state_next;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [CNT_W-1:0]  w_lat_next;
  logic [3:0]        r_addr;
  logic [3:0]        w_addr_next;
  logic [MESI_W-1:0] w_sel_state;
  logic              w_addr_ok;
  logic              w_trig;

  // Out-of-range addresses select nothing and can never trigger
  always_comb begin
    w_sel_state = MESI_I;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if (i_tb_ins_addr == 4'(i)) w_sel_state = i_state_cpu0[MESI_W*i +: MESI_W];
    end
  end

  assign w_addr_ok = 32'(i_tb_ins_addr) < NUM_LINES;
  assign w_trig    = w_addr_ok && is_owner(w_sel_state) && (i_tb_ins == INS_WR) &&
                     (i_c_state == C_STATE_IDLE) && (i_m_state == M_STATE_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TRK_IDLE;
      r_lat_cnt <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_next;
      r_addr    <= w_addr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat_cnt;
    w_addr_next  = r_addr;
    o_done_c     = 1'b0;
    o_timeout_c  = 1'b0;
    case (r_state)
      TRK_IDLE: begin
        if (i_en && w_trig) begin
          w_state_next = TRK_ARMED;
          w_lat_next   = CNT_W'(1);
          w_addr_next  = i_tb_ins_addr;
        end
      end
      TRK_ARMED: begin
        if (!i_en) begin
          w_state_next = TRK_IDLE;
        end else if (i_m_state == M_STATE_WR_CACHE) begin
          o_done_c     = 1'b1;
          w_state_next = TRK_IDLE;
        end else if (r_lat_cnt == CNT_W'(WR_TIMEOUT)) begin
          o_timeout_c  = 1'b1;
          w_state_next = TRK_IDLE;
        end else begin
          w_lat_next = r_lat_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = TRK_IDLE;
    endcase
  end

  assign o_lat_c  = r_lat_cnt;
  assign o_addr_c = r_addr;

endmodule

// File: rtl/mesi_isc_coherence_monitor.sv
// Coherence monitor: registers the four CPUs' MESI arrays, checks each line for
// single-owner and encoding violations, and reports first/count/latency results.
module mesi_isc_coherence_monitor
  import mesi_isc_mon_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 10,
  parameter int unsigned WR_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [MESI_W*NUM_LINES-1:0]  state_cpu0,
  input  logic [MESI_W*NUM_LINES-1:0]  state_cpu1,
  input  logic [MESI_W*NUM_LINES-1:0]  state_cpu2,
  input  logic [MESI_W*NUM_LINES-1:0]  state_cpu3,
  input  logic [3:0]                   c_state,
  input  logic [2:0]                   m_state,
  input  logic [3:0]                   tb_ins,
  input  logic [3:0]                   tb_ins_addr,
  output logic                         viol_valid,
  output logic [1:0]                   viol_code,
  output logic [3:0]                   viol_line,
  output logic [1:0]                   viol_cpu,
  output logic                         first_valid,
  output logic [1:0]                   first_code,
  output logic [3:0]                   first_line,
  output logic [1:0]                   first_cpu,
  output logic [CNT_W-1:0]             viol_cnt,
  output logic                         wr_lat_valid,
  output logic [CNT_W-1:0]             wr_lat,
  output logic [CNT_W-1:0]             wr_lat_max
);

  localparam int unsigned NUM_CPU = 4;
  localparam int unsigned SV_W    = MESI_W * NUM_LINES;

  logic [NUM_CPU-1:0][SV_W-1:0]   r_state;
  logic [3:0]                     r_c_state;
  logic [2:0]                     r_m_state;
  logic [3:0]                     r_tb_ins;
  logic [3:0]                     r_tb_ins_addr;

  logic [NUM_CPU-1:0][MESI_W-1:0] w_st;
  line_res_t                      w_res;
  logic                           w_line_hit;
  viol_rec_t                      w_line_rec;

  logic                           w_trk_done;
  logic                           w_trk_to;
  logic [CNT_W-1:0]               w_trk_lat;
  logic [3:0]                     w_trk_addr;

  logic                           w_line_evt;
  logic                           w_evt;
  viol_rec_t                      w_to_rec;
  viol_rec_t                      w_viol_rec;
  viol_rec_t                      w_first_rec;
  logic [CNT_W-1:0]               w_cnt_base;
  logic [CNT_W:0]                 w_cnt_sum;
  logic [CNT_W-1:0]               w_cnt_next;
  logic [CNT_W-1:0]               w_max_base;
  logic [CNT_W-1:0]               w_max_next;

  // Stage 1: input capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= '0;
      r_c_state     <= '0;
      r_m_state     <= '0;
      r_tb_ins      <= '0;
      r_tb_ins_addr <= '0;
    end else begin
      r_state       <= {state_cpu3, state_cpu2, state_cpu1, state_cpu0};
      r_c_state     <= c_state;
      r_m_state     <= m_state;
      r_tb_ins      <= tb_ins;
      r_tb_ins_addr <= tb_ins_addr;
    end
  end

  // Illegal encoding overrides multi-owner; the lowest offending CPU is named
  function automatic line_res_t check_line(input logic [NUM_CPU-1:0][MESI_W-1:0] st,
                                           input logic [3:0] line);
    line_res_t res;
    logic      other;
    res = '0;
    for (int c = int'(NUM_CPU) - 1; c >= 0; c--) begin
      other = 1'b0;
      for (int d = 0; d < int'(NUM_CPU); d++) begin
        if ((d != c) && (st[d] != MESI_I)) other = 1'b1;
      end
      if (is_owner(st[c]) && other) begin
        res.hit      = 1'b1;
        res.rec.code = VIOL_MULTI_OWNER;
        res.rec.cpu  = 2'(c);
      end
    end
    for (int c = int'(NUM_CPU) - 1; c >= 0; c--) begin
      if (!is_legal(st[c])) begin
        res.hit      = 1'b1;
        res.rec.code = VIOL_ILLEGAL_ENC;
        res.rec.cpu  = 2'(c);
      end
    end
    res.rec.line = line;
    return res;
  endfunction

  // Scan downward so the lowest violating line is the one kept
  always_comb begin
    w_line_hit = 1'b0;
    w_line_rec = '0;
    w_st       = '0;
    w_res      = '0;
    for (int l = int'(NUM_LINES) - 1; l >= 0; l--) begin
      for (int c = 0; c < int'(NUM_CPU); c++) w_st[c] = r_state[c][MESI_W*l +: MESI_W];
      w_res = check_line(w_st, 4'(l));
      if (w_res.hit) begin
        w_line_hit = 1'b1;
        w_line_rec = w_res.rec;
      end
    end
  end

  mesi_isc_mon_wr_tracker #(
    .NUM_LINES  (NUM_LINES),
    .WR_TIMEOUT (WR_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wr_tracker (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .i_state_cpu0  (r_state[0]),
    .i_c_state     (r_c_state),
    .i_m_state     (r_m_state),
    .i_tb_ins      (r_tb_ins),
    .i_tb_ins_addr (r_tb_ins_addr),
    .o_done_c      (w_trk_done),
    .o_timeout_c   (w_trk_to),
    .o_lat_c       (w_trk_lat),
    .o_addr_c      (w_trk_addr)
  );

  // Line violations own viol_*; a coincident timeout still claims first_*
  assign w_line_evt  = en && w_line_hit;
  assign w_evt       = w_line_evt || w_trk_to;
  assign w_to_rec    = '{code: VIOL_WR_TIMEOUT, line: w_trk_addr, cpu: 2'd0};
  assign w_viol_rec  = w_line_evt ? w_line_rec : w_to_rec;
  assign w_first_rec = w_trk_to ? w_to_rec : w_line_rec;

  assign w_cnt_base  = clr ? '0 : viol_cnt;
  assign w_cnt_sum   = (CNT_W+1)'(w_cnt_base) + (CNT_W+1)'(w_line_evt) + (CNT_W+1)'(w_trk_to);
  assign w_cnt_next  = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  assign w_max_base  = clr ? '0 : wr_lat_max;
  assign w_max_next  = (w_trk_done && (w_trk_lat > w_max_base)) ? w_trk_lat : w_max_base;

  // Stage 2: registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_valid   <= 1'b0;
      viol_code    <= '0;
      viol_line    <= '0;
      viol_cpu     <= '0;
      first_valid  <= 1'b0;
      first_code   <= '0;
      first_line   <= '0;
      first_cpu    <= '0;
      viol_cnt     <= '0;
      wr_lat_valid <= 1'b0;
      wr_lat       <= '0;
      wr_lat_max   <= '0;
    end else begin
      viol_valid <= w_evt;
      {viol_code, viol_line, viol_cpu} <= w_evt ? w_viol_rec : '0;
      if ((clr || !first_valid) && w_evt) begin
        first_valid <= 1'b1;
        {first_code, first_line, first_cpu} <= w_first_rec;
      end else if (clr) begin
        first_valid <= 1'b0;
        first_code  <= '0;
        first_line  <= '0;
        first_cpu   <= '0;
      end
      viol_cnt     <= w_cnt_next;
      wr_lat_valid <= w_trk_done;
      if (w_trk_done) wr_lat <= w_trk_lat;
      wr_lat_max   <= w_max_next;
    end
  end

endmodule

// File: tb/tb_mesi_isc_coherence_monitor.sv
// Directed bench for the coherence monitor with hand-computed expectations.
module tb_mesi_isc_coherence_monitor;
  import mesi_isc_mon_pkg::*;

  localparam int unsigned NL = 10;
  localparam int unsigned CW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b1;
  logic               clr = 1'b0;
  logic [3:0][4*NL-1:0] st = '0;
  logic [3:0]         c_state = '0;
  logic [2:0]         m_state = '0;
  logic [3:0]         tb_ins = '0;
  logic [3:0]         tb_ins_addr = '0;
  logic               viol_valid;
  logic [1:0]         viol_code;
  logic [3:0]         viol_line;
  logic [1:0]         viol_cpu;
  logic               first_valid;
  logic [1:0]         first_code;
  logic [3:0]         first_line;
  logic [1:0]         first_cpu;
  logic [CW-1:0]      viol_cnt;
  logic               wr_lat_valid;
  logic [CW-1:0]      wr_lat;
  logic [CW-1:0]      wr_lat_max;

  int   chk = 0;
  int   pass = 0;
  int   n;
  logic any;

  mesi_isc_coherence_monitor #(.NUM_LINES(NL), .WR_TIMEOUT(64), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .state_cpu0(st[0]), .state_cpu1(st[1]), .state_cpu2(st[2]), .state_cpu3(st[3]),
    .c_state(c_state), .m_state(m_state), .tb_ins(tb_ins), .tb_ins_addr(tb_ins_addr),
    .viol_valid(viol_valid), .viol_code(viol_code), .viol_line(viol_line), .viol_cpu(viol_cpu),
    .first_valid(first_valid), .first_code(first_code), .first_line(first_line),
    .first_cpu(first_cpu), .viol_cnt(viol_cnt), .wr_lat_valid(wr_lat_valid),
    .wr_lat(wr_lat), .wr_lat_max(wr_lat_max)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int cpu, input int line, input logic [3:0] v);
    st[cpu][4*line +: 4] = v;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic arm_line7();
    tb_ins = INS_WR;
    tb_ins_addr = 4'd7;
    tick();
    tb_ins = INS_NOP;
  endtask

  task automatic test_reset();
    tick(); tick();
    chk++; if (viol_valid !== 1'b0) $display("FAIL rst_viol_valid got %0d exp 0", viol_valid); else pass++;
    chk++; if (viol_cnt !== 16'd0) $display("FAIL rst_viol_cnt got %0d exp 0", viol_cnt); else pass++;
    chk++; if (first_valid !== 1'b0) $display("FAIL rst_first_valid got %0d exp 0", first_valid); else pass++;
    chk++; if (wr_lat_max !== 16'd0) $display("FAIL rst_wr_lat_max got %0d exp 0", wr_lat_max); else pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_no_violation();
    set_line(0, 3, MESI_M);
    any = 1'b0;
    repeat (20) begin
      tick();
      if (viol_valid !== 1'b0) any = 1'b1;
    end
    chk++; if (any !== 1'b0) $display("FAIL nov_any_valid got %0d exp 0", any); else pass++;
    chk++; if (viol_cnt !== 16'd0) $display("FAIL nov_viol_cnt got %0d exp 0", viol_cnt); else pass++;
  endtask

  task automatic test_multi_owner();
    set_line(1, 5, MESI_E);
    set_line(2, 5, MESI_S);
    tick();
    set_line(1, 5, MESI_I);
    set_line(2, 5, MESI_I);
    chk++; if (viol_valid !== 1'b0) $display("FAIL mo_t1_valid got %0d exp 0", viol_valid); else pass++;
    tick();
    chk++; if (viol_valid !== 1'b1) $display("FAIL mo_valid got %0d exp 1", viol_valid); else pass++;
    chk++; if (viol_code !== 2'd1) $display("FAIL mo_code got %0d exp 1", viol_code); else pass++;
    chk++; if (viol_line !== 4'd5) $display("FAIL mo_line got %0d exp 5", viol_line); else pass++;
    chk++; if (viol_cpu !== 2'd1) $display("FAIL mo_cpu got %0d exp 1", viol_cpu); else pass++;
    chk++; if (first_valid !== 1'b1) $display("FAIL mo_first_valid got %0d exp 1", first_valid); else pass++;
    chk++; if (viol_cnt !== 16'd1) $display("FAIL mo_cnt got %0d exp 1", viol_cnt); else pass++;
    tick();
    chk++; if (viol_valid !== 1'b0) $display("FAIL mo_pulse_end got %0d exp 0", viol_valid); else pass++;
  endtask

  task automatic test_write_hit();
    set_line(0, 7, MESI_E);
    arm_line7();
    tick(); tick(); tick();
    m_state = M_STATE_WR_CACHE;
    tick();
    m_state = M_STATE_IDLE;
    chk++; if (wr_lat_valid !== 1'b0) $display("FAIL wh_early got %0d exp 0", wr_lat_valid); else pass++;
    tick();
    chk++; if (wr_lat_valid !== 1'b1) $display("FAIL wh_valid got %0d exp 1", wr_lat_valid); else pass++;
    chk++; if (wr_lat !== 16'd4) $display("FAIL wh_lat got %0d exp 4", wr_lat); else pass++;
    chk++; if (wr_lat_max !== 16'd4) $display("FAIL wh_lat_max got %0d exp 4", wr_lat_max); else pass++;
    tick();
    chk++; if (wr_lat_valid !== 1'b0) $display("FAIL wh_pulse_end got %0d exp 0", wr_lat_valid); else pass++;
  endtask

  task automatic test_timeout();
    pulse_clr();
    chk++; if (first_valid !== 1'b0) $display("FAIL clr_first_valid got %0d exp 0", first_valid); else pass++;
    chk++; if (viol_cnt !== 16'd0) $display("FAIL clr_cnt got %0d exp 0", viol_cnt); else pass++;
    chk++; if (wr_lat_max !== 16'd0) $display("FAIL clr_lat_max got %0d exp 0", wr_lat_max); else pass++;
    arm_line7();
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (viol_valid === 1'b1) break;
    end
    chk++; if (n !== 65) $display("FAIL to_cycles got %0d exp 65", n); else pass++;
    chk++; if (viol_code !== 2'd3) $display("FAIL to_code got %0d exp 3", viol_code); else pass++;
    chk++; if (viol_line !== 4'd7) $display("FAIL to_line got %0d exp 7", viol_line); else pass++;
    chk++; if (first_code !== 2'd3) $display("FAIL to_first_code got %0d exp 3", first_code); else pass++;
    chk++; if (viol_cnt !== 16'd1) $display("FAIL to_cnt got %0d exp 1", viol_cnt); else pass++;
  endtask

  task automatic test_multi_line_clr();
    pulse_clr();
    set_line(0, 2, MESI_M); set_line(1, 2, MESI_S);
    set_line(2, 8, MESI_E); set_line(3, 8, MESI_E);
    tick();
    set_line(0, 2, MESI_I); set_line(1, 2, MESI_I);
    set_line(2, 8, MESI_I); set_line(3, 8, MESI_I);
    set_line(3, 0, 4'hF);
    tick();
    set_line(3, 0, MESI_I);
    chk++; if (viol_code !== 2'd1) $display("FAIL ml_code1 got %0d exp 1", viol_code); else pass++;
    chk++; if (viol_line !== 4'd2) $display("FAIL ml_line1 got %0d exp 2", viol_line); else pass++;
    chk++; if (viol_cpu !== 2'd0) $display("FAIL ml_cpu1 got %0d exp 0", viol_cpu); else pass++;
    chk++; if (viol_cnt !== 16'd1) $display("FAIL ml_cnt1 got %0d exp 1", viol_cnt); else pass++;
    tick();
    chk++; if (viol_code !== 2'd2) $display("FAIL ml_code2 got %0d exp 2", viol_code); else pass++;
    chk++; if (viol_line !== 4'd0) $display("FAIL ml_line2 got %0d exp 0", viol_line); else pass++;
    chk++; if (viol_cpu !== 2'd3) $display("FAIL ml_cpu2 got %0d exp 3", viol_cpu); else pass++;
    chk++; if (viol_cnt !== 16'd2) $display("FAIL ml_cnt2 got %0d exp 2", viol_cnt); else pass++;
    chk++; if (first_line !== 4'd2) $display("FAIL ml_first_line got %0d exp 2", first_line); else pass++;
    pulse_clr();
    chk++; if (viol_cnt !== 16'd0) $display("FAIL ml_clr_cnt got %0d exp 0", viol_cnt); else pass++;
    chk++; if (first_valid !== 1'b0) $display("FAIL ml_clr_first got %0d exp 0", first_valid); else pass++;
  endtask

  task automatic test_clr_collision();
    set_line(1, 9, MESI_M); set_line(0, 9, MESI_S);
    tick();
    set_line(1, 9, MESI_I); set_line(0, 9, MESI_I);
    tick();
    chk++; if (first_line !== 4'd9) $display("FAIL cc_pre_line got %0d exp 9", first_line); else pass++;
    set_line(0, 4, 4'b0110); set_line(1, 4, MESI_M);
    tick();
    set_line(0, 4, MESI_I); set_line(1, 4, MESI_I);
    pulse_clr();
    chk++; if (viol_code !== 2'd2) $display("FAIL cc_code got %0d exp 2", viol_code); else pass++;
    chk++; if (viol_cpu !== 2'd0) $display("FAIL cc_cpu got %0d exp 0", viol_cpu); else pass++;
    chk++; if (viol_cnt !== 16'd1) $display("FAIL cc_cnt got %0d exp 1", viol_cnt); else pass++;
    chk++; if (first_valid !== 1'b1) $display("FAIL cc_first_valid got %0d exp 1", first_valid); else pass++;
    chk++; if (first_code !== 2'd2) $display("FAIL cc_first_code got %0d exp 2", first_code); else pass++;
    chk++; if (first_line !== 4'd4) $display("FAIL cc_first_line got %0d exp 4", first_line); else pass++;
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    arm_line7();
    repeat (63) tick();
    set_line(2, 1, MESI_M); set_line(3, 1, MESI_S);
    tick();
    set_line(2, 1, MESI_I); set_line(3, 1, MESI_I);
    chk++; if (viol_valid !== 1'b0) $display("FAIL bb_early got %0d exp 0", viol_valid); else pass++;
    tick();
    chk++; if (viol_valid !== 1'b1) $display("FAIL bb_valid got %0d exp 1", viol_valid); else pass++;
    chk++; if (viol_code !== 2'd1) $display("FAIL bb_code got %0d exp 1", viol_code); else pass++;
    chk++; if (viol_line !== 4'd1) $display("FAIL bb_line got %0d exp 1", viol_line); else pass++;
    chk++; if (viol_cpu !== 2'd2) $display("FAIL bb_cpu got %0d exp 2", viol_cpu); else pass++;
    chk++; if (viol_cnt !== 16'd2) $display("FAIL bb_cnt got %0d exp 2", viol_cnt); else pass++;
    chk++; if (first_code !== 2'd3) $display("FAIL bb_first_code got %0d exp 3", first_code); else pass++;
    chk++; if (first_line !== 4'd7) $display("FAIL bb_first_line got %0d exp 7", first_line); else pass++;
  endtask

  task automatic test_enable();
    en = 1'b0;
    set_line(0, 6, MESI_M); set_line(1, 6, MESI_E);
    tick();
    set_line(0, 6, MESI_I); set_line(1, 6, MESI_I);
    any = 1'b0;
    repeat (3) begin
      tick();
      if (viol_valid !== 1'b0) any = 1'b1;
    end
    en = 1'b1;
    chk++; if (any !== 1'b0) $display("FAIL en_valid got %0d exp 0", any); else pass++;
    chk++; if (viol_cnt !== 16'd2) $display("FAIL en_cnt got %0d exp 2", viol_cnt); else pass++;
  endtask

  task automatic test_reset_while_armed();
    arm_line7();
    repeat (10) tick();
    rst = 1'b0;
    #1;
    chk++; if (viol_cnt !== 16'd0) $display("FAIL rwa_cnt got %0d exp 0", viol_cnt); else pass++;
    chk++; if (first_valid !== 1'b0) $display("FAIL rwa_first_valid got %0d exp 0", first_valid); else pass++;
    chk++; if (first_code !== 2'd0) $display("FAIL rwa_first_code got %0d exp 0", first_code); else pass++;
    chk++; if (wr_lat !== 16'd0) $display("FAIL rwa_wr_lat got %0d exp 0", wr_lat); else pass++;
    chk++; if (viol_valid !== 1'b0) $display("FAIL rwa_viol_valid got %0d exp 0", viol_valid); else pass++;
    m_state = M_STATE_WR_CACHE;
    tick(); tick();
    rst = 1'b1;
    any = 1'b0;
    repeat (3) begin
      tick();
      if (wr_lat_valid !== 1'b0 || viol_valid !== 1'b0) any = 1'b1;
    end
    m_state = M_STATE_IDLE;
    repeat (80) begin
      tick();
      if (wr_lat_valid !== 1'b0 || viol_valid !== 1'b0) any = 1'b1;
    end
    chk++; if (any !== 1'b0) $display("FAIL rwa_post_pulse got %0d exp 0", any); else pass++;
    chk++; if (viol_cnt !== 16'd0) $display("FAIL rwa_post_cnt got %0d exp 0", viol_cnt); else pass++;
  endtask

  initial begin
    test_reset();
    test_no_violation();
    test_multi_owner();
    test_write_hit();
    test_timeout();
    test_multi_line_clr();
    test_clr_collision();
    test_back_to_back();
    test_enable();
    test_reset_while_armed();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
